// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of one synchronous single-port data memory.
// One access in flight at a time. Memory-side outputs are registered. Each
// port sees a gnt pulse when its inputs are captured and an ack pulse when the
// access completes.
module mem_port_arbiter #(
   parameter int unsigned DW        = 16,
   parameter int unsigned AW        = 16,
   parameter int unsigned MEM_LAT   = 1,
   parameter int unsigned FIXED_PRI = 0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_req0,
   input  logic          i_we0,
   input  logic [AW-1:0] i_addr0,
   input  logic [DW-1:0] i_wdata0,
   input  logic          i_req1,
   input  logic          i_we1,
   input  logic [AW-1:0] i_addr1,
   input  logic [DW-1:0] i_wdata1,
   output logic          o_gnt0,
   output logic          o_gnt1,
   output logic          o_ack0,
   output logic          o_ack1,
   output logic [DW-1:0] o_rdata,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   output logic          o_mem_we,
   input  logic [DW-1:0] i_mem_rdata
);

   localparam int unsigned CW = $clog2(MEM_LAT) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

   typedef enum logic {StIdle, StAccess} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_owner, w_owner_nxt;
   logic          r_is_write, w_is_write_nxt;
   logic          r_last, w_last_nxt;
   logic          r_gnt0, w_gnt0_nxt;
   logic          r_gnt1, w_gnt1_nxt;
   logic          r_ack0, w_ack0_nxt;
   logic          r_ack1, w_ack1_nxt;
   logic [DW-1:0] r_rdata, w_rdata_nxt;
   logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
   logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
   logic          r_mem_we, w_mem_we_nxt;
   logic          w_win;

   // State register; reset clears everything and marks port 1 as last winner
   // so that the first round-robin tie goes to port 0.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_owner     <= 1'b0;
         r_is_write  <= 1'b0;
         r_last      <= 1'b1;
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
         r_ack0      <= 1'b0;
         r_ack1      <= 1'b0;
         r_rdata     <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_owner     <= w_owner_nxt;
         r_is_write  <= w_is_write_nxt;
         r_last      <= w_last_nxt;
         r_gnt0      <= w_gnt0_nxt;
         r_gnt1      <= w_gnt1_nxt;
         r_ack0      <= w_ack0_nxt;
         r_ack1      <= w_ack1_nxt;
         r_rdata     <= w_rdata_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_mem_we    <= w_mem_we_nxt;
      end
   end

   // Winner selection: a lone request wins outright; a tie goes to port 0
   // in fixed mode, otherwise to the port that did not win last time.
   always_comb begin
      w_win = i_req1;
      if (i_req0 && i_req1) begin
         w_win = (FIXED_PRI != 0) ? 1'b0 : ~r_last;
      end
   end

   // Next-state and output decode. Pulses default low, so gnt and the write
   // strobe last exactly one cycle.
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_owner_nxt      = r_owner;
      w_is_write_nxt   = r_is_write;
      w_last_nxt       = r_last;
      w_gnt0_nxt       = 1'b0;
      w_gnt1_nxt       = 1'b0;
      w_ack0_nxt       = 1'b0;
      w_ack1_nxt       = 1'b0;
      w_rdata_nxt      = r_rdata;
      w_mem_addr_nxt   = r_mem_addr;
      w_mem_wdata_nxt  = r_mem_wdata;
      w_mem_we_nxt     = 1'b0;
      case (r_state)
         StIdle: begin
            if (i_req0 || i_req1) begin
               w_gnt0_nxt      = ~w_win;
               w_gnt1_nxt      = w_win;
               w_mem_addr_nxt  = w_win ? i_addr1  : i_addr0;
               w_mem_wdata_nxt = w_win ? i_wdata1 : i_wdata0;
               w_mem_we_nxt    = w_win ? i_we1    : i_we0;
               w_is_write_nxt  = w_win ? i_we1    : i_we0;
               w_owner_nxt     = w_win;
               w_last_nxt      = w_win;
               w_cnt_nxt       = CNT_INIT;
               w_state_nxt     = StAccess;
            end
         end
         StAccess: begin
            // Requests are ignored here; writes wait the same latency as reads.
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CW'(1);
            end else begin
               w_ack0_nxt  = ~r_owner;
               w_ack1_nxt  = r_owner;
               if (!r_is_write) begin
                  w_rdata_nxt = i_mem_rdata;
               end
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   assign o_gnt0      = r_gnt0;
   assign o_gnt1      = r_gnt1;
   assign o_ack0      = r_ack0;
   assign o_ack1      = r_ack1;
   assign o_rdata     = r_rdata;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_we    = r_mem_we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Two instances: u_dut0 (latency 1, round-robin)
// and u_dut1 (latency 3, fixed priority). Each sits on a small memory model.
// A transaction-level reference predicts every output on every cycle.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst      [2];
   logic        req      [2][2];
   logic        we       [2][2];
   logic [15:0] addr     [2][2];
   logic [15:0] wd       [2][2];
   logic        gnt0     [2];
   logic        gnt1     [2];
   logic        ack0     [2];
   logic        ack1     [2];
   logic        mem_we   [2];
   logic [15:0] rdata    [2];
   logic [15:0] mem_addr [2];
   logic [15:0] mem_wdata[2];
   logic [15:0] mem_rdata[2];

   mem_port_arbiter #(.DW(16), .AW(16), .MEM_LAT(1), .FIXED_PRI(0)) u_dut0 (
      .i_clk(clk), .i_rst(rst[0]),
      .i_req0(req[0][0]), .i_we0(we[0][0]), .i_addr0(addr[0][0]), .i_wdata0(wd[0][0]),
      .i_req1(req[0][1]), .i_we1(we[0][1]), .i_addr1(addr[0][1]), .i_wdata1(wd[0][1]),
      .o_gnt0(gnt0[0]), .o_gnt1(gnt1[0]), .o_ack0(ack0[0]), .o_ack1(ack1[0]),
      .o_rdata(rdata[0]), .o_mem_addr(mem_addr[0]), .o_mem_wdata(mem_wdata[0]),
      .o_mem_we(mem_we[0]), .i_mem_rdata(mem_rdata[0])
   );

   mem_port_arbiter #(.DW(16), .AW(16), .MEM_LAT(3), .FIXED_PRI(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst[1]),
      .i_req0(req[1][0]), .i_we0(we[1][0]), .i_addr0(addr[1][0]), .i_wdata0(wd[1][0]),
      .i_req1(req[1][1]), .i_we1(we[1][1]), .i_addr1(addr[1][1]), .i_wdata1(wd[1][1]),
      .o_gnt0(gnt0[1]), .o_gnt1(gnt1[1]), .o_ack0(ack0[1]), .o_ack1(ack1[1]),
      .o_rdata(rdata[1]), .o_mem_addr(mem_addr[1]), .o_mem_wdata(mem_wdata[1]),
      .o_mem_we(mem_we[1]), .i_mem_rdata(mem_rdata[1])
   );

   function automatic logic [15:0] initv(int k);
      logic [7:0] b;
      b = 8'(k);
      return (k == 4) ? 16'h1234 : {b, ~b};
   endfunction

   function automatic int lat(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic bit fixed_pri(int i);
      return i != 0;
   endfunction

   // Memory models: contents reload while reset is held; read data appears
   // exactly MEM_LAT cycles after the address changes.
   logic [15:0] mem0 [256];
   logic [15:0] mem1 [256];
   logic [15:0] pipe1[2];

   always @(posedge clk) begin
      if (rst[0]) for (int k = 0; k < 256; k++) mem0[k] <= initv(k);
      else if (mem_we[0]) mem0[mem_addr[0][7:0]] <= mem_wdata[0];
   end
   assign mem_rdata[0] = mem0[mem_addr[0][7:0]];

   always @(posedge clk) begin
      if (rst[1]) for (int k = 0; k < 256; k++) mem1[k] <= initv(k);
      else if (mem_we[1]) mem1[mem_addr[1][7:0]] <= mem_wdata[1];
      pipe1[0] <= mem1[mem_addr[1][7:0]];
      pipe1[1] <= pipe1[0];
   end
   assign mem_rdata[1] = pipe1[1];

   // Reference model: cycle numbers of grant, ack and next acceptance.
   int          m_cyc [2];
   int          m_next[2];
   int          m_ack [2];
   int          m_own [2];
   bit          m_last[2];
   bit          m_isw [2];
   logic [15:0] m_pend[2];
   logic [15:0] refm  [2][256];
   bit          e_gnt [2][2];
   bit          e_ack [2][2];
   bit          e_we  [2];
   logic [15:0] e_rdata[2];
   logic [15:0] e_addr [2];
   logic [15:0] e_wdata[2];
   bit          hold  [2][2];
   int          gq0[$];
   int          gq1[$];
   int          passed = 0;
   int          total  = 0;
   int          fails  = 0;

   task automatic chk(input string tag, input int i, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s[%0d]: observed %h, expected %h", tag, i, obs, exp);
      end
   endtask

   task automatic model_edge(input int i);
      int          w;
      logic [15:0] a;
      e_gnt[i][0] = 0; e_gnt[i][1] = 0;
      e_ack[i][0] = 0; e_ack[i][1] = 0;
      e_we[i]     = 0;
      if (rst[i]) begin
         m_cyc[i] = 0; m_next[i] = 0; m_ack[i] = -1; m_last[i] = 1;
         e_rdata[i] = '0; e_addr[i] = '0; e_wdata[i] = '0;
         for (int k = 0; k < 256; k++) refm[i][k] = initv(k);
         return;
      end
      if (m_cyc[i] == m_ack[i]) begin
         e_ack[i][m_own[i]] = 1;
         if (!m_isw[i]) e_rdata[i] = m_pend[i];
      end
      if (m_cyc[i] >= m_next[i] && (req[i][0] || req[i][1])) begin
         if (req[i][0] && req[i][1]) w = fixed_pri(i) ? 0 : (m_last[i] ? 0 : 1);
         else w = req[i][1] ? 1 : 0;
         a = addr[i][w];
         e_gnt[i][w] = 1;
         e_we[i]     = we[i][w];
         e_addr[i]   = a;
         e_wdata[i]  = wd[i][w];
         m_own[i]    = w;
         m_last[i]   = (w == 1);
         m_isw[i]    = we[i][w];
         if (we[i][w]) refm[i][a[7:0]] = wd[i][w];
         else m_pend[i] = refm[i][a[7:0]];
         m_ack[i]  = m_cyc[i] + lat(i);
         m_next[i] = m_cyc[i] + lat(i) + 1;
      end
      m_cyc[i]++;
   endtask

   task automatic tick();
      for (int i = 0; i < 2; i++) model_edge(i);
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("gnt0", i, 16'(gnt0[i]), 16'(e_gnt[i][0]));
         chk("gnt1", i, 16'(gnt1[i]), 16'(e_gnt[i][1]));
         chk("ack0", i, 16'(ack0[i]), 16'(e_ack[i][0]));
         chk("ack1", i, 16'(ack1[i]), 16'(e_ack[i][1]));
         chk("mem_we", i, 16'(mem_we[i]), 16'(e_we[i]));
         chk("mem_addr", i, mem_addr[i], e_addr[i]);
         chk("mem_wdata", i, mem_wdata[i], e_wdata[i]);
         chk("rdata", i, rdata[i], e_rdata[i]);
         for (int p = 0; p < 2; p++)
            if (e_gnt[i][p] && !hold[i][p]) req[i][p] = 1'b0;
      end
      if (gnt0[0]) gq0.push_back(0);
      if (gnt1[0]) gq0.push_back(1);
      if (gnt0[1]) gq1.push_back(0);
      if (gnt1[1]) gq1.push_back(1);
   endtask

   task automatic set_req(input int i, input int p, input bit w, input logic [15:0] a,
                          input logic [15:0] d);
      req[i][p] = 1'b1; we[i][p] = w; addr[i][p] = a; wd[i][p] = d;
   endtask

   initial begin
      int ones;
      int zeros;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1;
         for (int p = 0; p < 2; p++) begin
            req[i][p] = 0; we[i][p] = 0; addr[i][p] = '0; wd[i][p] = '0; hold[i][p] = 0;
         end
      end

      // Reset held with request activity, then idle after release.
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++) set_req(i, p, 1'($urandom), 16'($urandom), 16'($urandom));
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         req[i][0] = 0; req[i][1] = 0; rst[i] = 1'b0;
      end
      for (int c = 0; c < 3; c++) tick();

      // Write BEEF to 0010 through port 0, read it back through port 1.
      set_req(0, 0, 1'b1, 16'h0010, 16'hBEEF);
      tick();
      chk("t2_mem_we", 0, 16'(mem_we[0]), 16'h1);
      chk("t2_mem_addr", 0, mem_addr[0], 16'h0010);
      chk("t2_mem_wdata", 0, mem_wdata[0], 16'hBEEF);
      tick();
      chk("t2_ack0", 0, 16'(ack0[0]), 16'h1);
      chk("t2_we_drop", 0, 16'(mem_we[0]), 16'h0);
      set_req(0, 1, 1'b0, 16'h0010, 16'h0000);
      tick();
      tick();
      chk("t2_ack1", 0, 16'(ack1[0]), 16'h1);
      chk("t2_rdata", 0, rdata[0], 16'hBEEF);

      // Round-robin with both ports held high.
      hold[0][0] = 1; hold[0][1] = 1;
      set_req(0, 0, 1'b0, 16'h0020, 16'h0);
      set_req(0, 1, 1'b0, 16'h0021, 16'h0);
      gq0.delete();
      for (int c = 0; c < 12; c++) tick();
      chk("t3_count", 0, 16'(gq0.size()), 16'd6);
      for (int k = 0; k < 6 && k < gq0.size(); k++) chk("t3_order", k, 16'(gq0[k]), 16'(k % 2));
      hold[0][0] = 0; hold[0][1] = 0; req[0][0] = 0; req[0][1] = 0;
      tick();

      // Latency 3 read of 0004; port 1 raised mid-access waits for ack0.
      set_req(1, 0, 1'b0, 16'h0004, 16'h0);
      tick();
      chk("t5_gnt0", 1, 16'(gnt0[1]), 16'h1);
      set_req(1, 1, 1'b0, 16'h0008, 16'h0);
      tick();
      chk("t5_no_gnt1_a", 1, 16'(gnt1[1]), 16'h0);
      tick();
      chk("t5_no_ack_early", 1, 16'(ack0[1]), 16'h0);
      tick();
      chk("t5_ack0", 1, 16'(ack0[1]), 16'h1);
      chk("t5_rdata", 1, rdata[1], 16'h1234);
      chk("t5_no_gnt1_b", 1, 16'(gnt1[1]), 16'h0);
      tick();
      chk("t5_gnt1", 1, 16'(gnt1[1]), 16'h1);
      for (int c = 0; c < 3; c++) tick();

      // Fixed priority with both held: port 0 every time, then port 1.
      hold[1][0] = 1; hold[1][1] = 1;
      set_req(1, 0, 1'b0, 16'h0030, 16'h0);
      set_req(1, 1, 1'b0, 16'h0031, 16'h0);
      gq1.delete();
      for (int c = 0; c < 16; c++) tick();
      ones = 0; zeros = 0;
      foreach (gq1[k]) if (gq1[k] == 1) ones++; else zeros++;
      chk("t4_gnt1_count", 1, 16'(ones), 16'd0);
      chk("t4_gnt0_count", 1, 16'(zeros), 16'd4);
      hold[1][0] = 0; req[1][0] = 0;
      tick();
      chk("t4_gnt1_after", 1, 16'(gnt1[1]), 16'h1);
      hold[1][1] = 0; req[1][1] = 0;
      for (int c = 0; c < 4; c++) tick();

      // Reset during a port 1 write: strobe drops at once, no ack follows.
      set_req(1, 1, 1'b1, 16'h0040, 16'hCAFE);
      tick();
      chk("t6_gnt1", 1, 16'(gnt1[1]), 16'h1);
      chk("t6_we_high", 1, 16'(mem_we[1]), 16'h1);
      #2 rst[1] = 1'b1;
      #1;
      chk("t6_we_async", 1, 16'(mem_we[1]), 16'h0);
      chk("t6_gnt_async", 1, 16'(gnt1[1]), 16'h0);
      chk("t6_addr_async", 1, mem_addr[1], 16'h0000);
      tick();
      tick();
      rst[1] = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      set_req(1, 0, 1'b0, 16'h0040, 16'h0);
      tick();
      chk("t6_idle_gnt0", 1, 16'(gnt0[1]), 16'h1);
      for (int c = 0; c < 3; c++) tick();
      chk("t6_rdata", 1, rdata[1], initv(16'h40));

      // Randomized traffic on both instances.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++)
               if (!req[i][p] && $urandom_range(0, 2) == 0)
                  set_req(i, p, 1'($urandom), {8'($urandom), 8'($urandom_range(0, 15))},
                          16'($urandom));
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
